alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Sequential front end that accepts operation commands over a valid/ready handshake and drives the combinational ALU operand/opcode inputs. It captures the ALU result and status {o,c,n,z}, and returns them over a valid/ready response channel. It extends the 32-bit ALU to 64-bit add/sub by chaining two passes through the ALU carry. It also counts completed operations.

Parameters:
CNT_W, 16, width of completed-operation counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  0 ADD, 1 XOR, 2 AND, 3 OR, 4 NOR, 5 SL, 6 SR, 7 SUB, 8 ADD64, 9 SUB64, 10-15 illegal
cmd_a  input  64  operand A; bits [63:32] used only by ops 8/9
cmd_b  input  64  operand B; bits [63:32] used only by ops 8/9
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_opcode  output  3  to ALU opcode
alu_sub  output  1  to ALU sub
alu_cin  output  1  to ALU Cin
alu_result  input  32  from ALU result
alu_status  input  4  from ALU status {o,c,n,z}
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  64  result; [63:32]=0 for 32-bit ops
rsp_flags  output  4  {o,c,n,z}
rsp_err  output  1  illegal opcode
op_count  output  CNT_W  responses delivered, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, op_count=0. ALU drive is idle.
- Idle ALU drive (any state not executing): alu_a=0, alu_b=0, alu_opcode=3'b111, alu_sub=0, alu_cin=0.
- States: IDLE, EXEC, EXEC_LO, EXEC_HI, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_op/cmd_a/cmd_b.
  - Ops 0-7 go to EXEC.
  - Ops 8-9 go to EXEC_LO.
  - Ops 10-15 go directly to RESP with rsp_data=0, rsp_flags=0, rsp_err=1.
- cmd_ready=0 in all states except IDLE. No command queuing.
- EXEC (one cycle): drive alu_a=A[31:0], alu_b=B[31:0].
  - Ops 0-6: alu_opcode=cmd_op, alu_sub=0, alu_cin=0.
  - Op 7 (SUB): alu_opcode=000, alu_sub=1, alu_cin=0.
  - At end of cycle, capture rsp_data={32'b0,alu_result}, rsp_flags=alu_status, rsp_err=0. Go to RESP.
- EXEC_LO: alu_opcode=000, alu_sub=0, alu_a=A[31:0].
  - ADD64: alu_b=B[31:0], alu_cin=0.
  - SUB64: alu_b=~B[31:0], alu_cin=1.
  - Capture lo=alu_result, carry=alu_status[2], zlo=alu_status[0]. Go to EXEC_HI.
- EXEC_HI: alu_opcode=000, alu_sub=0, alu_a=A[63:32], alu_b=B[63:32] (ADD64) or ~B[63:32] (SUB64), alu_cin=carry.
  - Capture rsp_data={alu_result,lo}.
  - Capture rsp_flags={alu_status[3],alu_status[2],alu_status[1],alu_status[0]&zlo}. Go to RESP.
- ALU is combinational: capture occurs on the same edge that ends the driving state.
- Latency from accept edge to rsp_valid: 2 cycles for 32-bit ops, 3 for 64-bit, 1 for illegal.
- RESP: rsp_valid=1. rsp_data/rsp_flags/rsp_err are stable until rsp_ready=1 is sampled.
  - On handshake: go to IDLE; op_count += 1 unless all-ones.
  - Next command accepted no earlier than the cycle after the handshake.
- Reset mid-operation: immediate return to reset values. The in-flight command is discarded and not counted.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
- Reset asserted mid EXEC_HI -> rsp_valid=0, cmd_ready=1, op_count=0 asynchronously; ALU drive returns to opcode 111.
- ADD op 0, A=5, B=3, rsp_ready=1 -> rsp_valid at accept+2; rsp_data=0x8; flags=4'b0000; observed ALU drive opcode=000, sub=0, cin=0.
- SUB op 7, A=3, B=3 -> rsp_data=0; flags z=1; alu_sub=1 during EXEC.
- ADD64, A=0x00000000_FFFFFFFF, B=0x1 -> rsp_valid at accept+3; EXEC_HI alu_cin=1; rsp_data=0x00000001_00000000; flags {o,c,n,z}=0000.
- SUB64, A=0, B=1 -> EXEC_LO alu_b=0xFFFFFFFE, alu_cin=1; rsp_data=0xFFFFFFFF_FFFFFFFF; flags=0010.
- Illegal op 12 -> rsp_valid at accept+1, rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 for 5 cycles -> outputs stable, cmd_ready=0; op_count increments by exactly 1 on release.
- Force op_count to all-ones -> one more handshake leaves op_count at all-ones.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Sequential front end for a 32-bit combinational ALU. Commands arrive over a
// valid/ready handshake. The sequencer drives the ALU operand/opcode inputs
// and captures the ALU result and status {o,c,n,z}. It returns them over a
// valid/ready response channel. ADD64/SUB64 are built from two chained ALU
// passes, with the low-pass carry feeding the high-pass carry-in.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_a, cmd_b           opcode (0-9 legal) and 64-bit operands
//   alu_a/alu_b/alu_opcode/
//   alu_sub/alu_cin                registered drive into the ALU
//   alu_result, alu_status         combinational ALU outputs {o,c,n,z}
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_flags, rsp_err   captured result, flags, illegal-op marker
//   op_count                       saturating count of delivered responses
module alu_cmd_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_sub,
  output logic             alu_cin,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_EXEC_LO = 3'd2,
    S_EXEC_HI = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [63:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        lo_q, lo_d;
  logic               carry_q, carry_d, zlo_q, zlo_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]         alu_opcode_q, alu_opcode_d;
  logic               alu_sub_q, alu_sub_d, alu_cin_q, alu_cin_d;

  // Next-state, capture and ALU-drive computation.
  // The ALU drive is registered, so it is derived from the *next* state and
  // next operands. It is then valid for the whole cycle the ALU is evaluated in.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_d        = lo_q;
    carry_d     = carry_q;
    zlo_d       = zlo_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (cmd_op <= 4'd7) begin
            state_d = S_EXEC;
          end else if (cmd_op <= 4'd9) begin
            state_d = S_EXEC_LO;
          end else begin
            state_d     = S_RESP;
            rsp_data_d  = 64'd0;
            rsp_flags_d = 4'd0;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_data_d  = {32'd0, alu_result};
        rsp_flags_d = alu_status;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_EXEC_LO: begin
        lo_d    = alu_result;
        carry_d = alu_status[2];
        zlo_d   = alu_status[0];
        state_d = S_EXEC_HI;
      end
      S_EXEC_HI: begin
        rsp_data_d  = {alu_result, lo_q};
        // 64-bit zero needs both halves zero; o/c/n come from the high pass.
        rsp_flags_d = {alu_status[3], alu_status[2], alu_status[1], alu_status[0] & zlo_q};
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            op_count_d = op_count_q;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    alu_a_d      = 32'd0;
    alu_b_d      = 32'd0;
    alu_opcode_d = 3'b111;
    alu_sub_d    = 1'b0;
    alu_cin_d    = 1'b0;
    case (state_d)
      S_EXEC: begin
        alu_a_d = a_d[31:0];
        alu_b_d = b_d[31:0];
        if (op_d == 4'd7) begin
          alu_opcode_d = 3'b000;
          alu_sub_d    = 1'b1;
        end else begin
          alu_opcode_d = op_d[2:0];
          alu_sub_d    = 1'b0;
        end
      end
      S_EXEC_LO: begin
        alu_a_d      = a_d[31:0];
        alu_opcode_d = 3'b000;
        // SUB64 is A + ~B + 1; the +1 enters on the low pass only.
        if (op_d == 4'd9) begin
          alu_b_d   = ~b_d[31:0];
          alu_cin_d = 1'b1;
        end else begin
          alu_b_d   = b_d[31:0];
          alu_cin_d = 1'b0;
        end
      end
      S_EXEC_HI: begin
        alu_a_d      = a_d[63:32];
        alu_opcode_d = 3'b000;
        alu_cin_d    = carry_d;
        if (op_d == 4'd9) begin
          alu_b_d = ~b_d[63:32];
        end else begin
          alu_b_d = b_d[63:32];
        end
      end
      default: begin
        alu_opcode_d = 3'b111;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, operand, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      lo_q         <= 32'd0;
      carry_q      <= 1'b0;
      zlo_q        <= 1'b0;
      rsp_data_q   <= 64'd0;
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      op_count_q   <= {CNT_W{1'b0}};
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_opcode_q <= 3'b111;
      alu_sub_q    <= 1'b0;
      alu_cin_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lo_q         <= lo_d;
      carry_q      <= carry_d;
      zlo_q        <= zlo_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      op_count_q   <= op_count_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_sub_q    <= alu_sub_d;
      alu_cin_q    <= alu_cin_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_sub    = alu_sub_q;
  assign alu_cin    = alu_cin_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. It contains a behavioural model of
// the 32-bit ALU and checks a table of directed vectors. It then runs
// randomized commands against a plain-arithmetic 64-bit reference model.
module tb_alu_cmd_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [63:0]      cmd_a, cmd_b;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [2:0]       alu_opcode;
  logic             alu_sub, alu_cin;
  logic [3:0]       alu_status;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [63:0]      rsp_data;
  logic [3:0]       rsp_flags;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_sub(alu_sub), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU: opcode 0 add (sub inverts B and forces carry-in),
  // 1 xor, 2 and, 3 or, 4 nor, 5 shift left, 6 shift right by B[4:0].
  logic [31:0] m_bb, m_res;
  logic        m_ci, m_o, m_c;
  logic [32:0] m_sum;
  always_comb begin
    m_bb  = alu_sub ? ~alu_b : alu_b;
    m_ci  = alu_sub | alu_cin;
    m_sum = {1'b0, alu_a} + {1'b0, m_bb} + {32'd0, m_ci};
    m_res = 32'd0;
    m_o   = 1'b0;
    m_c   = 1'b0;
    case (alu_opcode)
      3'd0: begin
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_o   = (alu_a[31] == m_bb[31]) && (m_sum[31] != alu_a[31]);
      end
      3'd1: m_res = alu_a ^ alu_b;
      3'd2: m_res = alu_a & alu_b;
      3'd3: m_res = alu_a | alu_b;
      3'd4: m_res = ~(alu_a | alu_b);
      3'd5: m_res = alu_a << alu_b[4:0];
      3'd6: m_res = alu_a >> alu_b[4:0];
      default: m_res = 32'd0;
    endcase
    alu_result = m_res;
    alu_status = {m_o, m_c, m_res[31], (m_res == 32'd0)};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results from plain 64/32-bit arithmetic; carry means "no borrow" for subtraction.
  task automatic ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] d, output logic [3:0] f, output logic e,
                           output int lat);
    logic [31:0] x, y, r;
    logic [64:0] w;
    logic o, c;
    x = a[31:0]; y = b[31:0]; o = 1'b0; c = 1'b0; r = 32'd0; w = 65'd0;
    if (op >= 4'd10) begin
      d = 64'd0; f = 4'd0; e = 1'b1; lat = 1;
    end else if (op >= 4'd8) begin
      if (op == 4'd8) begin
        w = {1'b0, a} + {1'b0, b};
        c = w[64];
        o = (a[63] == b[63]) && (w[63] != a[63]);
      end else begin
        w = {1'b0, a} - {1'b0, b};
        c = (a >= b);
        o = (a[63] != b[63]) && (w[63] != a[63]);
      end
      d = w[63:0]; f = {o, c, d[63], (d == 64'd0)}; e = 1'b0; lat = 3;
    end else begin
      case (op)
        4'd0: begin
          {c, r} = {1'b0, x} + {1'b0, y};
          o = (x[31] == y[31]) && (r[31] != x[31]);
        end
        4'd1: r = x ^ y;
        4'd2: r = x & y;
        4'd3: r = x | y;
        4'd4: r = ~(x | y);
        4'd5: r = x << y[4:0];
        4'd6: r = x >> y[4:0];
        default: begin
          r = x - y;
          c = (x >= y);
          o = (x[31] != y[31]) && (r[31] != x[31]);
        end
      endcase
      d = {32'd0, r}; f = {o, c, r[31], (r == 32'd0)}; e = 1'b0; lat = 2;
    end
  endtask

  // Issue one command and follow it to its handshake. Called just after a negedge.
  task automatic run_cmd(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ed, input logic [3:0] ef, input logic ee,
                         input int elat, input int hold);
    int guard, k;
    logic [31:0] bl, bh;
    logic lo_carry;
    bl = (op == 4'd9) ? ~b[31:0] : b[31:0];
    bh = (op == 4'd9) ? ~b[63:32] : b[63:32];
    lo_carry = ({1'b0, a[31:0]} + {1'b0, bl} + {32'd0, (op == 4'd9)}) >> 32;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (hold == 0);
    @(negedge clk);
    // Garbage on the command port while busy must be ignored.
    cmd_valid = 1'b1; cmd_op = 4'($urandom_range(0, 15));
    cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
    k = 1;
    while (!rsp_valid && k < 10) begin
      check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      if (op <= 4'd7) begin
        if (k == 1) begin
          check("exec_alu_a", 64'(alu_a), 64'(a[31:0]));
          check("exec_alu_b", 64'(alu_b), 64'(b[31:0]));
          check("exec_ctl", 64'({alu_opcode, alu_sub, alu_cin}),
                64'({(op == 4'd7) ? 3'd0 : op[2:0], (op == 4'd7), 1'b0}));
        end
      end else if (k == 1) begin
        check("lo_alu_a", 64'(alu_a), 64'(a[31:0]));
        check("lo_alu_b", 64'(alu_b), 64'(bl));
        check("lo_ctl", 64'({alu_opcode, alu_sub, alu_cin}), 64'({3'd0, 1'b0, (op == 4'd9)}));
      end else if (k == 2) begin
        check("hi_alu_a", 64'(alu_a), 64'(a[63:32]));
        check("hi_alu_b", 64'(alu_b), 64'(bh));
        check("hi_ctl", 64'({alu_opcode, alu_sub, alu_cin}), 64'({3'd0, 1'b0, lo_carry}));
      end
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    check("latency", 64'(k), 64'(elat));
    check("rsp_data", rsp_data, ed);
    check("rsp_flags", 64'(rsp_flags), 64'(ef));
    check("rsp_err", 64'(rsp_err), 64'(ee));
    check("resp_alu_idle", 64'({alu_opcode, alu_sub, alu_cin, alu_a, alu_b}), 64'({3'b111, 2'b00, 64'd0}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_data", rsp_data, ed);
      check("hold_flags_err", 64'({rsp_flags, rsp_err}), 64'({ef, ee}));
      check("hold_count", 64'(op_count), 64'(exp_count));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_count < (1 << CNT_W) - 1) exp_count++;
    check("post_hs_valid", 64'(rsp_valid), 64'd0);
    check("post_hs_ready", 64'(cmd_ready), 64'd1);
    check("op_count", 64'(op_count), 64'(exp_count));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b, data;
    logic [3:0]  flags;
    logic        err;
    int          lat, hold;
  } vec_t;
  vec_t vecs[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [63:0] ra, rb, rd;
    logic [3:0]  rf;
    logic        re;
    int          rl;

    vecs[0]  = '{4'd0, 64'd5, 64'd3, 64'd8, 4'b0000, 1'b0, 2, 0};
    vecs[1]  = '{4'd7, 64'd3, 64'd3, 64'd0, 4'b0101, 1'b0, 2, 0};
    vecs[2]  = '{4'd8, 64'h00000000_FFFFFFFF, 64'd1, 64'h00000001_00000000, 4'b0000, 1'b0, 3, 0};
    vecs[3]  = '{4'd9, 64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 4'b0010, 1'b0, 3, 0};
    vecs[4]  = '{4'd12, 64'hFFFFFFFF_FFFFFFFF, 64'd7, 64'd0, 4'b0000, 1'b1, 1, 0};
    vecs[5]  = '{4'd1, 64'hDEAD0000_F0F0F0F0, 64'hBEEF0000_FFFF0000, 64'h0F0FF0F0, 4'b0000, 1'b0, 2, 0};
    vecs[6]  = '{4'd2, 64'hFF00FF00, 64'h0F0F0F0F, 64'h0F000F00, 4'b0000, 1'b0, 2, 0};
    vecs[7]  = '{4'd3, 64'h80000000, 64'd1, 64'h80000001, 4'b0010, 1'b0, 2, 0};
    vecs[8]  = '{4'd4, 64'hFFFFFFFF, 64'd0, 64'd0, 4'b0001, 1'b0, 2, 0};
    vecs[9]  = '{4'd5, 64'd1, 64'd31, 64'h80000000, 4'b0010, 1'b0, 2, 0};
    vecs[10] = '{4'd6, 64'h80000000, 64'd4, 64'h08000000, 4'b0000, 1'b0, 2, 0};
    vecs[11] = '{4'd0, 64'h7FFFFFFF, 64'd1, 64'h80000000, 4'b1010, 1'b0, 2, 0};
    vecs[12] = '{4'd7, 64'd0, 64'd1, 64'hFFFFFFFF, 4'b0010, 1'b0, 2, 5};
    vecs[13] = '{4'd9, 64'h80000000_00000000, 64'd1, 64'h7FFFFFFF_FFFFFFFF, 4'b1100, 1'b0, 3, 0};
    vecs[14] = '{4'd8, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0, 4'b0101, 1'b0, 3, 0};
    vecs[15] = '{4'd8, 64'd1, 64'd0, 64'd1, 4'b0000, 1'b0, 3, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 64'd0; cmd_b = 64'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp", 64'({rsp_data[31:0], rsp_flags, rsp_err}) | 64'(rsp_data[63:32]), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_alu_drive", 64'({alu_opcode, alu_sub, alu_cin, alu_a, alu_b}), 64'({3'b111, 2'b00, 64'd0}));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].flags, vecs[i].err,
              vecs[i].lat, vecs[i].hold);
    end

    // Reset asserted while the high half of an ADD64 is being driven.
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 64'h00000000_FFFFFFFF; cmd_b = 64'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_hi_cin", 64'({alu_opcode, alu_cin}), 64'({3'd0, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_ready", 64'(cmd_ready), 64'd1);
    check("async_rst_count", 64'(op_count), 64'd0);
    check("async_rst_alu", 64'({alu_opcode, alu_sub, alu_cin}), 64'({3'b111, 2'b00}));
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_count", 64'(op_count), 64'd0);

    // Random traffic; enough handshakes to drive the counter into saturation.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (n % 7 == 3) rb = ra;
      ref_model(rop, ra, rb, rd, rf, re, rl);
      run_cmd(rop, ra, rb, rd, rf, re, rl, $urandom_range(0, 2));
    end
    check("count_saturated", 64'(op_count), 64'((1 << CNT_W) - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
